// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// writeback sources. Grants are combinational; the granted write is
// registered and issued one cycle later. Writes to $0 are accepted and
// counted but never strobed into the register file.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rf_hold,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_adr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [SRC_W-1:0]          wr_src,
  output logic [7:0]                zero_drops
);

  // Last granted requester; the search for the next winner starts just after it.
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  win_idx;
  logic              win_found;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Unpack the flat request buses and form the one-hot grant vector.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = accept && (win_idx == SRC_W'(gi));
    end
  endgenerate

  // Round-robin search: offset k from the pointer is checked before offset k+1.
  // Candidate i sits at offset k when rr_ptr == (i - k) mod NUM_REQ, which keeps
  // every index a constant and avoids run-time modulo arithmetic.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] &&
            (rr_ptr == SRC_W'((i - k + NUM_REQ) % NUM_REQ))) begin
          win_found = 1'b1;
          win_idx   = SRC_W'(i);
        end
      end
    end
  end

  // A grant is only offered outside reset and while the register file is available.
  assign accept   = rst_n && !rf_hold && win_found;
  assign sel_addr = addr_arr[win_idx];
  assign sel_data = data_arr[win_idx];

  // Register the accepted write; $0 targets are absorbed and counted instead of strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= SRC_W'(NUM_REQ - 1);
      wr_en      <= 1'b0;
      wr_adr     <= '0;
      wr_data    <= '0;
      wr_src     <= '0;
      zero_drops <= '0;
    end else if (accept) begin
      rr_ptr  <= win_idx;
      wr_adr  <= sel_addr;
      wr_data <= sel_data;
      wr_src  <= win_idx;
      wr_en   <= (sel_addr != '0);
      if ((sel_addr == '0) && (zero_drops != 8'hFF)) begin
        zero_drops <= zero_drops + 8'd1;
      end
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter (3 requesters, 16-bit data).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [47:0] req_data;
  logic        rf_hold;
  logic        wr_en;
  logic [4:0]  wr_adr;
  logic [15:0] wr_data;
  logic [1:0]  wr_src;
  logic [7:0]  zero_drops;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_hold(rf_hold),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .wr_src(wr_src),
    .zero_drops(zero_drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [47:0] data;
    logic        hold;
    logic [2:0]  ready;
    logic        en;
    logic [4:0]  adr;
    logic [15:0] wdata;
    logic [1:0]  src;
    logic [7:0]  zd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a2, a1, a0,
                              input logic [15:0] d2, d1, d0, input logic h,
                              input logic [2:0] rdy, input logic e, input logic [4:0] ad,
                              input logic [15:0] wd, input logic [1:0] s, input logic [7:0] z);
    vec_t r;
    r.valid = v; r.addr = {a2, a1, a0}; r.data = {d2, d1, d0}; r.hold = h;
    r.ready = rdy; r.en = e; r.adr = ad; r.wdata = wd; r.src = s; r.zd = z;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [47:0] d,
                       input logic h);
    req_valid = v; req_addr = a; req_data = d; rf_hold = h;
  endtask

  initial begin
    int sat_bad;
    // Vector table: state carries over from one entry to the next (pointer starts at 2).
    for (int i = 0; i < 6; i++)
      vecs[i] = mk(3'b111, 5'd3, 5'd2, 5'd1, 16'h3333, 16'h2222, 16'h1111, 1'b0,
                   3'b001 << (i % 3), 1'b1, 5'((i % 3) + 1),
                   (i % 3 == 0) ? 16'h1111 : (i % 3 == 1) ? 16'h2222 : 16'h3333,
                   2'(i % 3), 8'd0);
    vecs[6]  = mk(3'b010, 5'd0, 5'd0, 5'd0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 3'b010, 1'b0, 5'd0, 16'hBEEF, 2'd1, 8'd1);
    for (int i = 7; i < 10; i++)
      vecs[i] = mk(3'b101, 5'd5, 5'd0, 5'd4, 16'h5555, 16'h0, 16'h4444, 1'b1, 3'b000, 1'b0, 5'd0, 16'hBEEF, 2'd1, 8'd1);
    vecs[10] = mk(3'b101, 5'd5, 5'd0, 5'd4, 16'h5555, 16'h0, 16'h4444, 1'b0, 3'b100, 1'b1, 5'd5, 16'h5555, 2'd2, 8'd1);
    vecs[11] = mk(3'b001, 5'd0, 5'd0, 5'd4, 16'h0, 16'h0, 16'h4444, 1'b0, 3'b001, 1'b1, 5'd4, 16'h4444, 2'd0, 8'd1);
    vecs[12] = mk(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd4, 16'h4444, 2'd0, 8'd1);
    vecs[13] = mk(3'b010, 5'd0, 5'd9, 5'd0, 16'h0, 16'h9, 16'h0, 1'b0, 3'b010, 1'b1, 5'd9, 16'h9, 2'd1, 8'd1);
    vecs[14] = mk(3'b100, 5'd10, 5'd0, 5'd0, 16'hA, 16'h0, 16'h0, 1'b0, 3'b100, 1'b1, 5'd10, 16'hA, 2'd2, 8'd1);
    vecs[15] = mk(3'b101, 5'd7, 5'd0, 5'd7, 16'h2, 16'h0, 16'h1, 1'b0, 3'b001, 1'b1, 5'd7, 16'h1, 2'd0, 8'd1);
    vecs[16] = mk(3'b100, 5'd7, 5'd0, 5'd7, 16'h2, 16'h0, 16'h1, 1'b0, 3'b100, 1'b1, 5'd7, 16'h2, 2'd2, 8'd1);
    vecs[17] = mk(3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd7, 16'h2, 2'd2, 8'd1);
    vecs[18] = mk(3'b001, 5'd0, 5'd0, 5'd12, 16'h0, 16'h0, 16'hC, 1'b0, 3'b001, 1'b1, 5'd12, 16'hC, 2'd0, 8'd1);
    vecs[19] = mk(3'b001, 5'd0, 5'd0, 5'd13, 16'h0, 16'h0, 16'hD, 1'b1, 3'b000, 1'b0, 5'd12, 16'hC, 2'd0, 8'd1);
    vecs[20] = mk(3'b001, 5'd0, 5'd0, 5'd13, 16'h0, 16'h0, 16'hD, 1'b0, 3'b001, 1'b1, 5'd13, 16'hD, 2'd0, 8'd1);

    // Reset with all requesters valid: nothing granted, outputs clear.
    rst_n = 1'b0;
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_zero_drops", 32'(zero_drops), 32'h0);
    chk("rst_wr_adr", 32'(wr_adr), 32'h0);
    rst_n = 1'b1; #1;
    chk("rel_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("rel_wr_en", 32'(wr_en), 32'h1);
    chk("rel_wr_adr", 32'(wr_adr), 32'h1);
    $display("reset seq: first grant req0, wr_adr=%0d wr_en=%0b", wr_adr, wr_en);

    // Re-enter reset so the table starts from a known pointer.
    rst_n = 1'b0;
    drive(3'b000, '0, '0, 1'b0);
    #1;
    chk("rerst_wr_en", 32'(wr_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].hold);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_wr_adr", i), 32'(wr_adr), 32'(vecs[i].adr));
      chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_wr_src", i), 32'(wr_src), 32'(vecs[i].src));
      chk($sformatf("v%0d_zero_drops", i), 32'(zero_drops), 32'(vecs[i].zd));
      $display("vec %0d: valid=%b hold=%b ready=%b wr_en=%b adr=%0d data=%h src=%0d zd=%0d",
               i, req_valid, rf_hold, req_ready, wr_en, wr_adr, wr_data, wr_src, zero_drops);
    end

    // 300 writes to $0 from requester 1: counter saturates, no strobe ever issued.
    sat_bad = 0;
    drive(3'b010, '0, {16'h0, 16'hBEEF, 16'h0}, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (wr_en !== 1'b0 || req_ready !== 3'b010) sat_bad++;
    end
    chk("sat_no_strobe", 32'(sat_bad), 32'h0);
    chk("sat_zero_drops", 32'(zero_drops), 32'hFF);
    $display("saturation seq: zero_drops=%0d", zero_drops);

    // Async reset after a write has been registered: outputs clear at once.
    drive(3'b001, {5'd0, 5'd0, 5'd20}, {16'h0, 16'h0, 16'h0055}, 1'b0);
    @(posedge clk); #1;
    chk("t6_pre_wr_en", 32'(wr_en), 32'h1);
    chk("t6_pre_wr_adr", 32'(wr_adr), 32'd20);
    rst_n = 1'b0; #1;
    chk("t6_wr_en", 32'(wr_en), 32'h0);
    chk("t6_wr_adr", 32'(wr_adr), 32'h0);
    chk("t6_wr_data", 32'(wr_data), 32'h0);
    chk("t6_zero_drops", 32'(zero_drops), 32'h0);
    chk("t6_ready", 32'(req_ready), 32'h0);
    drive(3'b000, '0, '0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_wr_en", 32'(wr_en), 32'h0);
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
    #1;
    chk("t6_ptr_reinit", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("t6_after_src", 32'(wr_src), 32'h0);
    chk("t6_after_wr_en", 32'(wr_en), 32'h1);
    $display("async reset seq: wr_src=%0d wr_en=%0b", wr_src, wr_en);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
